seq_div: RTL
============

Name: seq_div

Overview:
- Sequential restoring divider, the inverse companion to the 32-bit ripple adder.
- Computes an unsigned quotient and remainder by repeated trial subtraction, one quotient bit per clock.
- Sits beside the adder in the ALU datapath and serves the DIV/REM operations behind a start/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 2).
- CW, $clog2(WIDTH+1), step-counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only while idle.
- dividend  input  WIDTH  numerator; captured on accepted start.
- divisor  input  WIDTH  denominator; captured on accepted start.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; results valid from this cycle on.
- quotient  output  WIDTH  result; held until the next accepted start.
- remainder  output  WIDTH  result; held until the next accepted start.
- div_by_zero  output  1  set with done when divisor was 0; held with the results.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high. On rst, all outputs = 0, state = IDLE, counter = 0.
- States:
  - IDLE: busy=0. start=1 at edge t0 loads operands and clears the result registers and div_by_zero.
    - divisor != 0: state goes to CALC, busy=1, counter=WIDTH.
    - divisor == 0: go to ZERO.
  - CALC: one step per edge, on edges t0+1 … t0+WIDTH.
    - Step: the partial remainder R (WIDTH+1 bits) shifts left and takes in the next dividend MSB. Compute D = R − {0,divisor} as the adder form R + ~divisor + 1.
    - If there is no borrow, R = D and the quotient bit is 1. Otherwise R is kept and the quotient bit is 0.
    - Counter decrements. At the edge where counter goes 1→0: quotient and remainder are registered, done=1, busy=0, state goes to IDLE.
    - Latency is exactly WIDTH edges from the start edge to done visible.
  - ZERO: at edge t0+1, quotient = all ones, remainder = dividend, div_by_zero=1, done=1, busy=0, state goes to IDLE.
- done is high for exactly one cycle, then returns to 0. Results persist.
- start while busy=1 is ignored, with no effect on the operation in flight.
- start in the same cycle done=1 is accepted, because the state is already IDLE.
- Operands are captured at start. Input changes while busy have no effect.
- rst mid-operation aborts the operation: no done pulse, outputs = 0. The next start behaves normally.
- Boundary cases: dividend=0 gives q=0, r=0. divisor > dividend gives q=0, r=dividend. divisor=1 gives q=dividend, r=0.
- Remainder is always < divisor, and dividend = q·divisor + r holds mod 2^WIDTH.

Optional Feature:
- Macro: SEQ_DIV_SIGNED_EN.
- When defined:
  - Extra input port sgn (1 bit), sampled with start. sgn=1 selects two's-complement division.
  - Operand magnitudes are taken at load. Signs are applied on the final step, so latency is unchanged.
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - MIN/−1 gives q=MIN, r=0.
  - Divide by zero gives q = −1 if dividend ≥ 0, else +1; r = dividend; div_by_zero=1.
- When undefined: no sgn port; unsigned only, exactly as above.

Decomposition:
- Package seq_div_pkg holds:
  - state enum {IDLE, CALC, ZERO};
  - WIDTH default;
  - CW derivation.
- One sub-module, div_step: combinational single restoring step.
  - Inputs: R, next dividend bit, divisor.
  - Outputs: next R, quotient bit.
  - Implements the subtract as add with inverted divisor and carry-in 1.
  - Instantiated once; the FSM iterates it.

Test Plan:
- 100 / 7 at t0 → busy 1 on t0+1..t0+32; done at t0+32 only; q=14, r=2, div_by_zero=0.
- 0xFFFFFFFF / 1, then 3 / 10 back-to-back (second start in the done cycle) → q=0xFFFFFFFF, r=0, then q=0, r=3, with no idle gap required.
- 5 / 0 → done at t0+1, q=0xFFFFFFFF, r=5, div_by_zero=1; next 9 / 3 clears it: q=3, r=0, div_by_zero=0.
- 1000 / 9 started, second start (50 / 5) pulsed at t0+5 → ignored; done at t0+32 with q=111, r=1.
- 1000 / 9 started, rst at t0+10 → no done; all outputs 0 after the reset edge; subsequent 8 / 3 → q=2, r=2 at 32 edges.
- SEQ_DIV_SIGNED_EN, sgn=1:
  - −7 / 2 → q=−3, r=−1.
  - 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0.
  - −4 / 0 → q=1, r=−4, div_by_zero=1.

Source files
------------

// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared definitions for the sequential restoring divider.
//   SEQ_DIV_WIDTH : default operand/result width
//   state_t       : controller states (IDLE, CALC, ZERO)
//   cw_of()       : width of a step counter that can hold the value WIDTH
package seq_div_pkg;

  localparam int SEQ_DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ZERO
  } state_t;

  // The counter is loaded with WIDTH itself, so it needs one value beyond
  // WIDTH-1.
  function automatic int cw_of(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// div_step: one combinational restoring-division step.
// Ports:
//   r       in  WIDTH  partial remainder from the previous step (always < divisor)
//   dbit    in  1      next dividend bit, MSB first
//   divisor in  WIDTH  denominator
//   r_next  out WIDTH  partial remainder after this step
//   qbit    out 1      quotient bit produced by this step
module div_step
  import seq_div_pkg::*;
#(
  parameter int WIDTH = SEQ_DIV_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic             qbit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           carry;
  logic           diff_msb_unused;

  // The incoming remainder is below the divisor, so the shifted value fits in
  // WIDTH+1 bits. The trial subtraction is done in adder form; a carry out of
  // R + ~{0,divisor} + 1 means no borrow, so the subtraction is kept.
  always_comb begin
    shifted         = {r, dbit};
    {carry, diff}   = {1'b0, shifted} + {1'b0, ~{1'b0, divisor}} + (WIDTH + 2)'(1);
    qbit            = carry;
    r_next          = carry ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    diff_msb_unused = diff[WIDTH];
  end

endmodule

// File: rtl/seq_div.sv
// seq_div: sequential restoring divider, one quotient bit per clock.
// Optional feature macro: SEQ_DIV_SIGNED_EN (adds 'sgn' for two's-complement).
// Ports:
//   clk         in  1      rising-edge clock
//   rst         in  1      synchronous active-high reset
//   start       in  1      request, sampled only while idle
//   dividend    in  WIDTH  numerator, captured on accepted start
//   divisor     in  WIDTH  denominator, captured on accepted start
//   sgn         in  1      (SEQ_DIV_SIGNED_EN only) signed division select
//   busy        out 1      division in progress
//   done        out 1      one-cycle pulse, results valid from here on
//   quotient    out WIDTH  result, held until next accepted start
//   remainder   out WIDTH  result, held until next accepted start
//   div_by_zero out 1      divisor was zero, held with results
module seq_div
  import seq_div_pkg::*;
#(
  parameter  int WIDTH = SEQ_DIV_WIDTH,
  localparam int CW    = cw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIV_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] r_work;
  logic             neg_q;
  logic             neg_r;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH-1:0] step_r;
  logic             step_q;
  logic [WIDTH-1:0] q_final;

  // Operand conditioning at load time: in signed mode the core only ever
  // sees magnitudes and the signs are remembered for the final step.
`ifdef SEQ_DIV_SIGNED_EN
  always_comb begin
    a_neg = sgn & dividend[WIDTH-1];
    b_neg = sgn & divisor[WIDTH-1];
    a_mag = a_neg ? -dividend : dividend;
    b_mag = b_neg ? -divisor : divisor;
  end
`else
  always_comb begin
    a_neg = 1'b0;
    b_neg = 1'b0;
    a_mag = dividend;
    b_mag = divisor;
  end
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .r       (r_work),
    .dbit    (dvd[WIDTH-1]),
    .divisor (dsr),
    .r_next  (step_r),
    .qbit    (step_q)
  );

  // Quotient bits are shifted into the bottom of the dividend register as its
  // bits are consumed from the top, so after the last step it holds the
  // quotient except for the bit being produced right now.
  assign q_final = {dvd[WIDTH-2:0], step_q};

  // Controller: accepts a request in IDLE, iterates the step WIDTH times in
  // CALC (or takes the one-cycle ZERO path), and registers the results.
  // MIN / -1 needs no special handling: the magnitude quotient is MIN and the
  // signs cancel, so it comes out as MIN with remainder 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      dvd         <= '0;
      dsr         <= '0;
      r_work      <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            r_work      <= '0;
            dsr         <= b_mag;
            neg_q       <= a_neg ^ b_neg;
            neg_r       <= a_neg;
            busy        <= 1'b1;
            if (divisor == '0) begin
              dvd   <= dividend;
              state <= ZERO;
            end else begin
              dvd   <= a_mag;
              count <= CW'(WIDTH);
              state <= CALC;
            end
          end
        end
        CALC: begin
          dvd    <= q_final;
          r_work <= step_r;
          count  <= count - CW'(1);
          if (count == CW'(1)) begin
            quotient  <= neg_q ? -q_final : q_final;
            remainder <= neg_r ? -step_r : step_r;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        ZERO: begin
          quotient    <= neg_r ? WIDTH'(1) : '1;
          remainder   <= dvd;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
